mult_seq_32: RTL and testbench

- Multi-cycle 32x32 -> 64-bit multiplier sequencer.
- Owns exactly one RC_ADD_SUB_32 instance as its only arithmetic resource. Drives that adder's B operand and SnA each cycle and retires one multiplier bit per cycle.
- Sits beside the ALU and serves the mul instruction, where a single-cycle 32x32 array is too costly.
- Signed mode uses radix-2 Booth recoding. Unsigned mode uses plain shift-add.

---
 rtl/mult_seq_32.sv | 132 +++++++++++++
 tb/tb_mult_seq_32.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_seq_32.sv
// rtl/mult_seq_32.sv - Multi-cycle 32x32->64 Booth/shift-add multiplier around one ripple add/sub.
// Optional MULT_EARLY_ZERO_EN: zero operand finishes one cycle after START.

module RC_ADD_SUB_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SnA,
    output logic [31:0] Y,
    output logic        CO
);
    logic [32:0] w_sum;

    assign w_sum = {1'b0, A} + {1'b0, B ^ {32{SnA}}} + {32'b0, SnA};
    assign Y     = w_sum[31:0];
    assign CO    = w_sum[32];
endmodule

module mult_seq_32 #(
    parameter int SIGNED_MODE = 1,
    parameter int ITERATIONS  = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    localparam logic [5:0] LAST_CNT = 6'(ITERATIONS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_m;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic        r_q_m1;
    logic [5:0]  r_cnt;

    logic        w_accept;
    logic        w_zero;
    logic        w_op;
    logic        w_sna;
    logic [31:0] w_y;
    logic        w_co;
    logic [31:0] w_eff;
    logic        w_v;
    logic [31:0] w_r;
    logic        w_s;

    assign w_accept = (r_state != S_CALC) && START;

`ifdef MULT_EARLY_ZERO_EN
    assign w_zero = (A == 32'd0) || (B == 32'd0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (START) w_next = w_zero ? S_FIN : S_CALC;
            S_CALC:  if (r_cnt == LAST_CNT) w_next = S_FIN;
            S_FIN:   w_next = START ? (w_zero ? S_FIN : S_CALC) : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (r_state == S_CALC);
        DONE = (r_state == S_FIN);
    end

    // Booth recode in signed mode; plain multiplier-bit test otherwise.
    always_comb begin
        w_op  = 1'b0;
        w_sna = 1'b0;
        if (SIGNED_MODE != 0) begin
            w_op  = r_q[0] ^ r_q_m1;
            w_sna = r_q[0] & ~r_q_m1;
        end else begin
            w_op  = r_q[0];
        end
    end

    RC_ADD_SUB_32 u_addsub (
        .A   (r_acc),
        .B   (r_m),
        .SnA (w_sna),
        .Y   (w_y),
        .CO  (w_co)
    );

    // The true sign of the 33-bit partial sum is R[31]^V; this keeps M=0x80000000 exact.
    assign w_eff = r_m ^ {32{w_sna}};
    assign w_v   = w_op && (r_acc[31] == w_eff[31]) && (w_y[31] != r_acc[31]);
    assign w_r   = w_op ? w_y : r_acc;
    assign w_s   = (SIGNED_MODE != 0) ? (w_r[31] ^ w_v) : (w_op & w_co);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m    <= 32'd0;
            r_acc  <= 32'd0;
            r_q    <= 32'd0;
            r_q_m1 <= 1'b0;
            r_cnt  <= 6'd0;
        end else if (w_accept) begin
            r_m    <= A;
            r_acc  <= 32'd0;
            r_q    <= w_zero ? 32'd0 : B;
            r_q_m1 <= 1'b0;
            r_cnt  <= 6'd0;
        end else if (r_state == S_CALC) begin
            r_acc  <= {w_s, w_r[31:1]};
            r_q    <= {w_r[0], r_q[31:1]};
            r_q_m1 <= r_q[0];
            r_cnt  <= r_cnt + 6'd1;
        end
    end

    assign HI = r_acc;
    assign LO = r_q;
endmodule

// File: tb/tb_mult_seq_32.sv
// tb/tb_mult_seq_32.sv - Randomized and directed checks of signed and unsigned mult_seq_32 against arithmetic products.

module tb_mult_seq_32;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy_s, done_s, busy_u, done_u;
    logic [31:0] hi_s, lo_s, hi_u, lo_u;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mult_seq_32 #(.SIGNED_MODE(1), .ITERATIONS(32)) u_sgn (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .BUSY(busy_s), .DONE(done_s), .HI(hi_s), .LO(lo_s)
    );

    mult_seq_32 #(.SIGNED_MODE(0), .ITERATIONS(32)) u_uns (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .BUSY(busy_u), .DONE(done_u), .HI(hi_u), .LO(lo_u)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return 64'(x * y);
    endfunction

    function automatic logic [63:0] ref_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_EARLY_ZERO_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // inj > 0 pulses a competing START (A=B=7) on that cycle of the operation.
    task automatic measure(input logic [31:0] a, input logic [31:0] b, input int inj);
        int lat;
        int busy_n;
        logic seen;
        logic [63:0] ps, pu;
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        ps = ref_signed(a, b);
        pu = ref_unsigned(a, b);
        while (!seen && lat < 100) begin
            @(negedge CLK);
            lat++;
            START = (lat == inj);
            if (lat == inj) begin
                A = 32'd7;
                B = 32'd7;
            end
            if (done_s) seen = 1'b1;
            else        busy_n += int'(busy_s);
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(exp_latency(a, b)));
        check("busy_cycles", 64'(busy_n), 64'(exp_latency(a, b) - 1));
        check("done_unsigned", 64'(done_u), 64'd1);
        check("busy_at_done", 64'({busy_s, busy_u}), 64'd0);
        check("signed_product", {hi_s, lo_s}, ps);
        check("unsigned_product", {hi_u, lo_u}, pu);
    endtask

    task automatic hold_check(input logic [31:0] a, input logic [31:0] b);
        repeat (3) @(negedge CLK);
        check("hold_signed", {hi_s, lo_s}, ref_signed(a, b));
        check("hold_unsigned", {hi_u, lo_u}, ref_unsigned(a, b));
        check("done_cleared", 64'({done_s, done_u}), 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        measure(a, b, 0);
        hold_check(a, b);
    endtask

    initial begin
        int n_done;
        logic [31:0] ra, rb;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_flags", 64'({busy_s, done_s, busy_u, done_u}), 64'd0);
        check("reset_hilo", {hi_s, lo_s}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFF9, 32'd6);
        run_op(32'h8000_0000, 32'h8000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h7FFF_FFFF, 32'h8000_0000);
        run_op(32'd0, 32'h0000_1234);
        run_op(32'h0000_1234, 32'd0);

        // Competing START mid-operation must be ignored.
        issue(32'd2, 32'd9);
        measure(32'd2, 32'd9, 10);
        n_done = 0;
        repeat (40) begin
            @(negedge CLK);
            n_done += int'(done_s);
        end
        check("no_extra_done", 64'(n_done), 64'd0);

        // START presented in the DONE cycle restarts with no idle gap.
        issue(32'd11, 32'd13);
        measure(32'd11, 32'd13, 0);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D);
        measure(32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
        hold_check(32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Reset in the middle of CALC aborts without a DONE.
        issue(32'd5, 32'd6);
        repeat (15) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("abort_flags", 64'({busy_s, done_s, busy_u, done_u}), 64'd0);
        check("abort_hilo", {hi_s, lo_s, hi_u, lo_u}, 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge CLK);
            n_done += int'(done_s) + int'(done_u);
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra[31] = 1'b1;
            if (i % 4 == 2) rb[31] = 1'b1;
            run_op(ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
